// File: rtl/branch_predict_unit.sv
// Fetch-stage branch predictor: direct-mapped BTB with per-entry saturating direction counters.
// Define BPU_RAS_EN to add a circular return-address stack for call/return prediction.
module branch_predict_unit #(
  parameter int ENTRIES   = 16,
  parameter int PC_WD     = 32,
  parameter int CNT_WD    = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic [PC_WD-1:0] fetch_PC,
  output logic [PC_WD-1:0] pred_PC,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [PC_WD-1:0] upd_PC,
  input  logic [1:0]       upd_kind,
  input  logic             upd_taken,
  input  logic [PC_WD-1:0] upd_target,
  input  logic             upd_mispredict,
  output logic [31:0]      mispred_cnt,
  output logic [31:0]      branch_cnt
);

  localparam int IDX_WD = $clog2(ENTRIES);
  localparam int TAG_WD = PC_WD - IDX_WD - 2;
  localparam logic [CNT_WD-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WD-1:0] CNT_WEAK = CNT_WD'(1) << (CNT_WD - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_WD-1:0]  tag_q    [ENTRIES];
  logic [PC_WD-1:0]   target_q [ENTRIES];
  logic [1:0]         kind_q   [ENTRIES];
  logic [CNT_WD-1:0]  cnt_q    [ENTRIES];
  logic [31:0]        branch_q;
  logic [31:0]        mispred_q;

  logic [IDX_WD-1:0] f_idx;
  logic [IDX_WD-1:0] u_idx;
  logic [TAG_WD-1:0] f_tag;
  logic [TAG_WD-1:0] u_tag;
  logic              hit;
  logic              u_hit;
  logic [PC_WD-1:0]  seq_pc;
  logic              unused_pc_low;

  assign f_idx  = fetch_PC[IDX_WD+1:2];
  assign f_tag  = fetch_PC[PC_WD-1:IDX_WD+2];
  assign u_idx  = upd_PC[IDX_WD+1:2];
  assign u_tag  = upd_PC[PC_WD-1:IDX_WD+2];
  assign seq_pc = fetch_PC + PC_WD'(4);
  assign unused_pc_low = ^{fetch_PC[1:0], upd_PC[1:0]};

  // Lookup is suppressed while reset is held so the outputs are clean from the first reset cycle.
  assign hit        = ~reset & fetch_valid & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
  assign pred_taken = hit & ((kind_q[f_idx] != 2'd0) | cnt_q[f_idx][CNT_WD-1]);
  assign u_hit      = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

`ifdef BPU_RAS_EN
  localparam int RAS_PW = $clog2(RAS_DEPTH);
  localparam logic [RAS_PW:0] RAS_FULL = (RAS_PW + 1)'(RAS_DEPTH);

  logic [PC_WD-1:0]  ras_q [RAS_DEPTH];
  logic [RAS_PW-1:0] ras_ptr;
  logic [RAS_PW:0]   ras_cnt;
  logic              ras_push;
  logic              ras_pop;

  // ras_ptr names the next free slot; the top of stack sits just below it.
  assign ras_push = pred_taken & (kind_q[f_idx] == 2'd2);
  assign ras_pop  = pred_taken & (kind_q[f_idx] == 2'd3) & (ras_cnt != '0);
  assign pred_PC  = ras_pop    ? ras_q[ras_ptr - RAS_PW'(1)] :
                    pred_taken ? target_q[f_idx] : seq_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + RAS_PW'(1);
      if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + (RAS_PW + 1)'(1);
    end else if (ras_pop) begin
      ras_ptr <= ras_ptr - RAS_PW'(1);
      ras_cnt <= ras_cnt - (RAS_PW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) ras_q[ras_ptr] <= seq_pc;
  end
`else
  localparam int unused_ras_depth = RAS_DEPTH;

  assign pred_PC = pred_taken ? target_q[f_idx] : seq_pc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_kind == 2'd0) begin
          if (upd_taken) begin
            target_q[u_idx] <= upd_target;
            if (cnt_q[u_idx] != CNT_MAX) cnt_q[u_idx] <= cnt_q[u_idx] + CNT_WD'(1);
          end else if (cnt_q[u_idx] != '0) begin
            cnt_q[u_idx] <= cnt_q[u_idx] - CNT_WD'(1);
          end
        end else begin
          target_q[u_idx] <= upd_target;
          kind_q[u_idx]   <= upd_kind;
          cnt_q[u_idx]    <= CNT_MAX;
        end
      end else if (upd_taken) begin
        // Allocation replaces whatever branch previously owned this index.
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        kind_q[u_idx]   <= upd_kind;
        cnt_q[u_idx]    <= (upd_kind == 2'd0) ? CNT_WEAK : CNT_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_q  <= '0;
      mispred_q <= '0;
    end else if (upd_valid) begin
      if (branch_q != '1) branch_q <= branch_q + 32'd1;
      if (upd_mispredict && mispred_q != '1) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign branch_cnt  = reset ? '0 : branch_q;
  assign mispred_cnt = reset ? '0 : mispred_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a slot/owner table model is compared every cycle,
// and directed scenarios pin the model with hand-computed values (RAS scenarios need BPU_RAS_EN).
module tb_branch_predict_unit;

  localparam int ENTRIES   = 16;
  localparam int PC_WD     = 32;
  localparam int CNT_WD    = 2;
  localparam int RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_PC;
  logic [31:0] pred_PC;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_PC;
  logic [1:0]  upd_kind;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] mispred_cnt;
  logic [31:0] branch_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .ENTRIES(ENTRIES), .PC_WD(PC_WD), .CNT_WD(CNT_WD), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_PC(fetch_PC),
    .pred_PC(pred_PC), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_PC(upd_PC), .upd_kind(upd_kind),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .mispred_cnt(mispred_cnt), .branch_cnt(branch_cnt)
  );

  // Model: each slot remembers the full word address of the branch owning it.
  bit          m_valid  [ENTRIES];
  logic [29:0] m_owner  [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_kind   [ENTRIES];
  int          m_cnt    [ENTRIES];
  longint      m_branch  = 0;
  longint      m_mispred = 0;
  logic [31:0] m_ras [$];

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic void model_predict(input bit fv, input logic [31:0] pc, input bit rst,
                                        output bit taken, output logic [31:0] npc,
                                        output bit push, output bit pop);
    int s;
    bit h;
    s     = slot(pc);
    h     = !rst && fv && m_valid[s] && (m_owner[s] == pc[31:2]);
    taken = h && (m_kind[s] != 0 || m_cnt[s] >= 2 ** (CNT_WD - 1));
    npc   = taken ? m_target[s] : pc + 32'd4;
    push  = 1'b0;
    pop   = 1'b0;
`ifdef BPU_RAS_EN
    if (taken && m_kind[s] == 2) push = 1'b1;
    if (taken && m_kind[s] == 3 && m_ras.size() > 0) begin
      pop = 1'b1;
      npc = m_ras[$];
    end
`endif
  endfunction

  always @(posedge clk) begin
    bit t, pu, po;
    logic [31:0] p;
    int s;
    bit h;
    model_predict(fetch_valid, fetch_PC, reset, t, p, pu, po);
    if (reset) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_branch  = 0;
      m_mispred = 0;
      m_ras.delete();
    end else begin
      if (pu) begin
        m_ras.push_back(fetch_PC + 32'd4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (po) begin
        void'(m_ras.pop_back());
      end
      if (upd_valid) begin
        if (m_branch < 64'hFFFF_FFFF) m_branch++;
        if (upd_mispredict && m_mispred < 64'hFFFF_FFFF) m_mispred++;
        s = slot(upd_PC);
        h = m_valid[s] && (m_owner[s] == upd_PC[31:2]);
        if (h && upd_kind == 2'd0) begin
          if (upd_taken) begin
            m_target[s] = upd_target;
            m_cnt[s]    = (m_cnt[s] + 1 > 2 ** CNT_WD - 1) ? 2 ** CNT_WD - 1 : m_cnt[s] + 1;
          end else begin
            m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
          end
        end else if (h) begin
          m_target[s] = upd_target;
          m_kind[s]   = int'(upd_kind);
          m_cnt[s]    = 2 ** CNT_WD - 1;
        end else if (upd_taken) begin
          m_valid[s]  = 1'b1;
          m_owner[s]  = upd_PC[31:2];
          m_target[s] = upd_target;
          m_kind[s]   = int'(upd_kind);
          m_cnt[s]    = (upd_kind == 2'd0) ? 2 ** (CNT_WD - 1) : 2 ** CNT_WD - 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit t, pu, po;
    logic [31:0] p;
    if (check_en) begin
      model_predict(fetch_valid, fetch_PC, reset, t, p, pu, po);
      checkOutput("model pred_taken", {31'b0, pred_taken}, {31'b0, t});
      checkOutput("model pred_PC", pred_PC, p);
      checkOutput("model branch_cnt", branch_cnt, reset ? 32'd0 : m_branch[31:0]);
      checkOutput("model mispred_cnt", mispred_cnt, reset ? 32'd0 : m_mispred[31:0]);
    end
  end

  task automatic applyStimulus(input bit rst, input bit fv, input logic [31:0] fpc,
                               input bit uv, input logic [31:0] upc, input logic [1:0] kind,
                               input bit tk, input logic [31:0] tgt, input bit mis);
    @(posedge clk);
    #1;
    reset = rst; fetch_valid = fv; fetch_PC = fpc;
    upd_valid = uv; upd_PC = upc; upd_kind = kind;
    upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
  endtask

  task automatic train(input logic [31:0] pc, input logic [1:0] kind, input bit tk,
                       input logic [31:0] tgt, input bit mis);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, pc, kind, tk, tgt, mis);
  endtask

  // One lookup cycle, then literal checks of the combinational prediction.
  task automatic lookAndCheck(input string name, input logic [31:0] pc,
                              input bit exp_taken, input logic [31:0] exp_pc);
    applyStimulus(1'b0, 1'b1, pc, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput({name, " taken"}, {31'b0, pred_taken}, {31'b0, exp_taken});
    checkOutput({name, " pc"}, pred_PC, exp_pc);
  endtask

  initial begin
    reset = 1'b1; fetch_valid = 1'b1; fetch_PC = 32'h1C00_0000;
    upd_valid = 1'b0; upd_PC = '0; upd_kind = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    check_en = 1'b1;

    lookAndCheck("after reset", 32'h1C00_0000, 1'b0, 32'h1C00_0004);
    checkOutput("after reset branch_cnt", branch_cnt, 32'd0);
    checkOutput("after reset mispred_cnt", mispred_cnt, 32'd0);

    train(32'h1C00_0010, 2'd0, 1'b1, 32'h1C00_0100, 1'b1);
    lookAndCheck("alloc cond", 32'h1C00_0010, 1'b1, 32'h1C00_0100);

    // 2 -> 1 -> 0, then a third not-taken must hold at 0 so one taken reaches only 1.
    train(32'h1C00_0010, 2'd0, 1'b0, 32'h0, 1'b1);
    train(32'h1C00_0010, 2'd0, 1'b0, 32'h0, 1'b1);
    lookAndCheck("cnt at 0", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
    train(32'h1C00_0010, 2'd0, 1'b0, 32'h0, 1'b0);
    train(32'h1C00_0010, 2'd0, 1'b1, 32'h1C00_0180, 1'b0);
    lookAndCheck("floor hold", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
    repeat (3) train(32'h1C00_0010, 2'd0, 1'b1, 32'h1C00_0180, 1'b0);
    lookAndCheck("cnt at 3", 32'h1C00_0010, 1'b1, 32'h1C00_0180);
    train(32'h1C00_0010, 2'd0, 1'b0, 32'h0, 1'b0);
    lookAndCheck("cnt 3 to 2", 32'h1C00_0010, 1'b1, 32'h1C00_0180);
    train(32'h1C00_0010, 2'd0, 1'b0, 32'h0, 1'b0);
    lookAndCheck("cnt 2 to 1", 32'h1C00_0010, 1'b0, 32'h1C00_0014);

    train(32'h1C00_0050, 2'd0, 1'b1, 32'h1C00_0500, 1'b0);
    lookAndCheck("alias evicted", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
    lookAndCheck("alias owner", 32'h1C00_0050, 1'b1, 32'h1C00_0500);

    applyStimulus(1'b0, 1'b1, 32'h1C00_0020, 1'b1, 32'h1C00_0020, 2'd0, 1'b1, 32'h1C00_0800, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("same cycle taken", {31'b0, pred_taken}, 32'd0);
    checkOutput("same cycle pc", pred_PC, 32'h1C00_0024);
    lookAndCheck("after same cycle", 32'h1C00_0020, 1'b1, 32'h1C00_0800);

    train(32'h1C00_0040, 2'd1, 1'b1, 32'h1C00_0444, 1'b0);
    lookAndCheck("uncond alloc", 32'h1C00_0040, 1'b1, 32'h1C00_0444);
    train(32'h1C00_0040, 2'd1, 1'b1, 32'h1C00_0555, 1'b0);
    lookAndCheck("uncond retarget", 32'h1C00_0040, 1'b1, 32'h1C00_0555);

    train(32'h1C00_0060, 2'd0, 1'b0, 32'h1C00_0666, 1'b0);
    lookAndCheck("miss not taken", 32'h1C00_0060, 1'b0, 32'h1C00_0064);

    applyStimulus(1'b0, 1'b0, 32'h1C00_0040, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("fetch invalid pc", pred_PC, 32'h1C00_0044);
    lookAndCheck("pc wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h1C00_0040, 1'b1, 32'h1C00_0070, 2'd1, 1'b1, 32'h1C00_0777, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("in reset taken", {31'b0, pred_taken}, 32'd0);
    checkOutput("in reset pc", pred_PC, 32'h1C00_0044);
    checkOutput("in reset branch_cnt", branch_cnt, 32'd0);
    lookAndCheck("reset beats update", 32'h1C00_0070, 1'b0, 32'h1C00_0074);
    lookAndCheck("reset clears valid", 32'h1C00_0040, 1'b0, 32'h1C00_0044);

    train(32'h1C00_0080, 2'd0, 1'b1, 32'h1C00_0880, 1'b1);
    train(32'h1C00_0080, 2'd0, 1'b0, 32'h0, 1'b0);
    train(32'h1C00_0084, 2'd1, 1'b1, 32'h1C00_0884, 1'b1);
    lookAndCheck("counters idle", 32'h1C00_0084, 1'b1, 32'h1C00_0884);
    checkOutput("three updates branch_cnt", branch_cnt, 32'd3);
    checkOutput("two mispredicts mispred_cnt", mispred_cnt, 32'd2);

`ifdef BPU_RAS_EN
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    train(32'h1C00_0204, 2'd2, 1'b1, 32'h1C00_1000, 1'b0);
    train(32'h1C00_0308, 2'd3, 1'b1, 32'h1C00_2000, 1'b0);
    lookAndCheck("ras call", 32'h1C00_0204, 1'b1, 32'h1C00_1000);
    lookAndCheck("ras return", 32'h1C00_0308, 1'b1, 32'h1C00_0208);
    for (int i = 0; i < 5; i++)
      train(32'h1C00_020C + 32'(4 * i), 2'd2, 1'b1, 32'h1C00_3000, 1'b0);
    for (int i = 0; i < 5; i++)
      lookAndCheck("ras nested call", 32'h1C00_020C + 32'(4 * i), 1'b1, 32'h1C00_3000);
    for (int i = 0; i < 4; i++)
      lookAndCheck("ras nested return", 32'h1C00_0308, 1'b1, 32'h1C00_0220 - 32'(4 * i));
    lookAndCheck("ras empty fallback", 32'h1C00_0308, 1'b1, 32'h1C00_2000);
`endif

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
